// File: rtl/dma_drain_arb.sv
// Read side of the 4-channel DMA FIFO bank: round-robin drains channel FIFOs one
// word at a time and presents each word with its per-channel destination address.

module dma_drain_ch #(
    parameter int AINC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic        inc,
    input  logic [31:0] ld_addr,
    output logic [31:0] addr
);
    // A config write on the same cycle as an accept wins over the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      addr <= '0;
        else if (ld)  addr <= ld_addr;
        else if (inc) addr <= addr + 32'(AINC);
    end
endmodule

module dma_drain_arb #(
    parameter int BURST = 4,
    parameter int AINC  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ch_en,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_ch,
    input  logic [31:0] cfg_addr,
    input  logic [3:0]  empty,
    output logic [3:0]  rd,
    input  logic [31:0] rdata_0,
    input  logic [31:0] rdata_1,
    input  logic [31:0] rdata_2,
    input  logic [31:0] rdata_3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [1:0]  out_ch,
    output logic        busy
);
    localparam int NUM_LANES = 4;
    localparam int CW = 5;

    typedef enum logic [1:0] {IDLE, READ, CAPT, SEND} state_t;

    state_t                             state, state_nxt;
    logic [1:0]                         g, g_nxt, rr, rr_nxt, pick;
    logic [CW-1:0]                      cnt, cnt_nxt;
    logic                               pick_vld, accept;
    logic [NUM_LANES-1:0]               elig, ld, inc;
    logic [NUM_LANES-1:0][31:0]         addr, rdata;

    assign elig   = ch_en & ~empty;
    assign rdata  = {rdata_3, rdata_2, rdata_1, rdata_0};
    assign accept = (state == SEND) && out_ready;

    generate
        for (genvar n = 0; n < NUM_LANES; n++) begin : g_ch
            assign ld[n]  = cfg_we && (cfg_ch == 2'(n));
            assign inc[n] = accept && (g == 2'(n));
            dma_drain_ch #(.AINC(AINC)) u_ch (
                .clk     (clk),
                .rst     (rst),
                .ld      (ld[n]),
                .inc     (inc[n]),
                .ld_addr (cfg_addr),
                .addr    (addr[n])
            );
        end
    endgenerate

    // Scan from the farthest offset down so the nearest eligible channel wins.
    always_comb begin
        logic [1:0] idx;
        pick_vld = 1'b0;
        pick     = rr;
        idx      = rr;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            idx = rr + 2'(i);
            if (elig[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        rr_nxt    = rr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (pick_vld) begin
                g_nxt     = pick;
                cnt_nxt   = '0;
                state_nxt = READ;
            end
            READ: if (elig[g]) begin
                state_nxt = CAPT;
            end else begin
                rr_nxt    = g + 2'd1;
                state_nxt = IDLE;
            end
            CAPT: state_nxt = SEND;
            SEND: if (out_ready) begin
                cnt_nxt = cnt + CW'(1);
                if ((cnt + CW'(1)) < CW'(BURST) && elig[g]) begin
                    state_nxt = READ;
                end else begin
                    rr_nxt    = g + 2'd1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            g        <= '0;
            rr       <= '0;
            cnt      <= '0;
            out_addr <= '0;
            out_data <= '0;
            out_ch   <= '0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            rr    <= rr_nxt;
            cnt   <= cnt_nxt;
            if (state == CAPT) begin
                out_data <= rdata[g];
                out_addr <= addr[g];
                out_ch   <= g;
            end
        end
    end

    // Strobe decoded from the state register; the empty recheck keeps reads off drained FIFOs.
    assign rd        = (state == READ && elig[g]) ? (4'd1 << g) : 4'd0;
    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_dma_drain_arb.sv
// Directed + randomized bench for dma_drain_arb with a queue-based FIFO model and
// a word-order reference model derived from the round-robin / burst rules.

module tb_dma_drain_arb;
    localparam int BURST = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  c;
    } w_t;

    logic        clk = 0, rst = 1;
    logic [3:0]  ch_en = 0, empty, rd;
    logic        cfg_we = 0, out_ready = 0, out_valid, busy;
    logic [1:0]  cfg_ch = 0, out_ch;
    logic [31:0] cfg_addr = 0, out_addr, out_data;
    logic [31:0] rdata_q [4];

    dma_drain_arb #(.BURST(BURST), .AINC(4)) dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_addr(cfg_addr), .empty(empty), .rd(rd),
        .rdata_0(rdata_q[0]), .rdata_1(rdata_q[1]), .rdata_2(rdata_q[2]), .rdata_3(rdata_q[3]),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .out_ch(out_ch), .busy(busy)
    );

    always #5 clk = ~clk;

    // Channel FIFO bank: data appears on rdata the cycle after rd.
    logic [31:0] mem [4][64];
    int          wp [4];
    int          rp [4];
    logic        flush = 0;

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (flush) rp[n] <= wp[n];
            else if (rd[n]) begin
                rdata_q[n] <= mem[n][rp[n] % 64];
                rp[n]      <= rp[n] + 1;
            end
        end
    end

    always_comb begin
        empty = '0;
        for (int n = 0; n < 4; n++) empty[n] = (wp[n] == rp[n]);
    end

    int          errors = 0, checks = 0;
    w_t          got [$];
    w_t          exp [$];
    logic [31:0] mq [4][$];
    logic [31:0] m_addr [4];
    int          m_rr = 0;
    int          rd_cnt [4];
    int          rdy_prob = 100;
    bit          hold_ready = 0, stall_prev = 0;
    w_t          prev_w;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic w_t cur_w();
        return {out_addr, out_data, out_ch};
    endfunction

    // One clock: protocol invariants, ready drive, accept capture (all at negedge).
    task automatic tick();
        @(negedge clk);
        if (rd != 0) begin
            chk("rd_onehot", 66'($onehot(rd)), 66'd1);
            chk("rd_not_empty", 66'(rd & empty), 66'd0);
        end
        for (int n = 0; n < 4; n++) rd_cnt[n] += int'(rd[n]);
        if (stall_prev) chk("stall_stable", {out_valid, cur_w()}, {1'b1, prev_w});
        if (!hold_ready) out_ready = ($urandom_range(99) < rdy_prob);
        if (out_valid && out_ready) got.push_back(cur_w());
        stall_prev = out_valid && !out_ready;
        prev_w     = cur_w();
    endtask

    task automatic accept_now();
        out_ready = 1;
        got.push_back(cur_w());
        stall_prev = 0;
    endtask

    task automatic push(input int ch, input logic [31:0] d);
        mem[ch][wp[ch] % 64] = d;
        wp[ch] = wp[ch] + 1;
        mq[ch].push_back(d);
    endtask

    task automatic cfg(input int ch, input logic [31:0] a);
        cfg_we = 1; cfg_ch = 2'(ch); cfg_addr = a;
        tick();
        cfg_we = 0;
        m_addr[ch] = a;
    endtask

    task automatic do_flush();
        flush = 1;
        tick();
        flush = 0;
        for (int n = 0; n < 4; n++) mq[n].delete();
    endtask

    // Reference: grant the first enabled non-empty channel from rr, take up to
    // BURST words, then move rr past the granted channel.
    task automatic model_drain(input logic [3:0] mask);
        int g;
        forever begin
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && mask[(m_rr + k) % 4] && mq[(m_rr + k) % 4].size() > 0)
                    g = (m_rr + k) % 4;
            if (g < 0) break;
            for (int b = 0; b < BURST && mq[g].size() > 0; b++) begin
                exp.push_back({m_addr[g], mq[g].pop_front(), 2'(g)});
                m_addr[g] = m_addr[g] + 32'd4;
            end
            m_rr = (g + 1) % 4;
        end
    endtask

    task automatic run(input int n, input string tag);
        int c = 0;
        int budget = 30 * n + 60;
        while ((got.size() < n || busy) && c < budget) begin
            tick();
            c++;
        end
        chk({tag, "_done"}, 66'(c < budget), 66'd1);
    endtask

    task automatic cmp_words(input string tag);
        chk({tag, "_count"}, 66'(got.size()), 66'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk({tag, "_word"}, got[i], exp[i]);
        got.delete();
        exp.delete();
    endtask

    task automatic wait_valid(input string tag);
        int c = 0;
        while (!out_valid && c < 50) begin
            tick();
            c++;
        end
        chk({tag, "_valid"}, 66'(out_valid), 66'd1);
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin
            wp[n] = 0; m_addr[n] = 0; rd_cnt[n] = 0;
        end
        tick(); tick();
        chk("reset_outs", {out_valid, rd, busy, out_addr, out_data, out_ch},
            {1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 2'd0});
        rst = 0;
        tick();

        // Round-robin with full bursts
        for (int n = 0; n < 4; n++) cfg(n, 32'h100 * (n + 1));
        for (int n = 0; n < 4; n++) for (int k = 0; k < 8; k++) push(n, $urandom);
        ch_en = 4'hF; rdy_prob = 100;
        model_drain(4'hF);
        run(32, "rr");
        cmp_words("rr");

        // Single channel, two words
        cfg(2, 32'h1000);
        push(2, 32'hA); push(2, 32'hB);
        ch_en = 4'b0100;
        for (int n = 0; n < 4; n++) rd_cnt[n] = 0;
        model_drain(4'b0100);
        run(2, "single");
        cmp_words("single");
        chk("single_rd2", 66'(rd_cnt[2]), 66'd2);
        chk("single_idle", 66'(busy), 66'd0);

        // Backpressure: stall 10 cycles in SEND, then exactly one accept
        ch_en = 4'b0010;
        push(1, $urandom); push(1, $urandom);
        hold_ready = 1; out_ready = 0;
        for (int n = 0; n < 4; n++) rd_cnt[n] = 0;
        wait_valid("bp");
        repeat (10) tick();
        chk("bp_one_read", 66'(rd_cnt[1]), 66'd1);
        chk("bp_hold_valid", 66'(out_valid), 66'd1);
        accept_now();
        tick();
        out_ready = 0;
        repeat (4) tick();
        chk("bp_one_accept", 66'(got.size()), 66'd1);
        hold_ready = 0;
        model_drain(4'b0010);
        run(2, "bp");
        cmp_words("bp");

        // Address wrap
        cfg(3, 32'hFFFF_FFFC);
        push(3, $urandom); push(3, $urandom);
        ch_en = 4'b1000;
        model_drain(4'b1000);
        run(2, "wrap");
        cmp_words("wrap");

        // ch_en cleared mid-burst: current word still delivered, rr moves on
        do_flush();
        ch_en = 4'b0001;
        for (int k = 0; k < 4; k++) push(0, $urandom);
        push(1, $urandom); push(1, $urandom);
        hold_ready = 1; out_ready = 0;
        wait_valid("chen");
        ch_en = 4'b0010;
        accept_now();
        exp.push_back({m_addr[0], mq[0].pop_front(), 2'd0});
        m_addr[0] = m_addr[0] + 32'd4;
        m_rr = 1;
        hold_ready = 0;
        model_drain(4'b0010);
        run(3, "chen");
        cmp_words("chen");
        do_flush();

        // cfg_we in the accept cycle: new address wins, in-flight word keeps old one
        cfg(2, 32'h2000);
        ch_en = 4'b0100;
        push(2, 32'hC0); push(2, 32'hC1);
        hold_ready = 1; out_ready = 0;
        wait_valid("cfgacc");
        accept_now();
        cfg_we = 1; cfg_ch = 2'd2; cfg_addr = 32'h5000;
        tick();
        cfg_we = 0;
        hold_ready = 0;
        exp.push_back({32'h2000, 32'hC0, 2'd2});
        exp.push_back({32'h5000, 32'hC1, 2'd2});
        mq[2].delete();
        m_addr[2] = 32'h5004; m_rr = 3;
        run(2, "cfgacc");
        cmp_words("cfgacc");

        // Empty guard: short channels release the grant early
        ch_en = 4'b0011;
        push(0, $urandom);
        push(1, $urandom); push(1, $urandom);
        model_drain(4'b0011);
        run(3, "empty");
        cmp_words("empty");

        // Randomized rounds with random backpressure
        for (int r = 0; r < 6; r++) begin
            logic [3:0] mask;
            ch_en = 0;
            for (int n = 0; n < 4; n++) cfg(n, $urandom & 32'hFFFF_FFFC);
            for (int n = 0; n < 4; n++) begin
                int cnt = $urandom_range(0, 9);
                for (int k = 0; k < cnt; k++) push(n, $urandom);
            end
            mask = 4'($urandom_range(1, 15));
            rdy_prob = $urandom_range(30, 100);
            ch_en = mask;
            model_drain(mask);
            run(exp.size(), "rand");
            cmp_words("rand");
            ch_en = 0;
            do_flush();
        end
        rdy_prob = 100;

        // Async reset in SEND
        cfg(0, 32'h3000);
        ch_en = 4'b0001;
        push(0, $urandom);
        hold_ready = 1; out_ready = 0;
        wait_valid("rst");
        #2 rst = 1;
        #1 chk("rst_same_cycle", {out_valid, rd, busy, out_addr}, {1'b0, 4'd0, 1'b0, 32'd0});
        stall_prev = 0;
        tick();
        rst = 0;
        do_flush();
        for (int n = 0; n < 4; n++) m_addr[n] = 0;
        m_rr = 0;
        hold_ready = 0;
        ch_en = 4'b1001;
        push(3, $urandom); push(0, $urandom);
        model_drain(4'b1001);
        run(2, "post_rst");
        cmp_words("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
